master_spi_core: RTL and testbench

MASTER_SPI_CORE -- requirements
Module: master_spi_core

---
 rtl/master_spi_core.sv | 217 +++++++++++++++++++++
 tb/tb_master_spi_core.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/master_spi_core.sv
// master_spi_core: single-lane SPI master, all four CPOL/CPHA modes.
// A word is accepted from a valid/ready handshake. Chip select then frames
// three phases: setup, 2*DATA_WIDTH sclk half-periods, and hold. Each phase
// is counted in half-periods of CLK_DIV pclk cycles. Every output is driven
// straight from a register.
// Optional feature macro: MASTER_SPI_LSB_FIRST_EN adds the lsb_first input.
// lsb_first is captured at accept and selects LSB-first shifting in both
// directions.
module master_spi_core #(
  parameter int DATA_WIDTH = 8,
  parameter int CLK_DIV    = 2,
  parameter int CS_SETUP   = 1,
  parameter int CS_HOLD    = 1
) (
  input  logic                  pclk,
  input  logic                  areset,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  input  logic                  cpol,
  input  logic                  cpha,
`ifdef MASTER_SPI_LSB_FIRST_EN
  input  logic                  lsb_first,
`endif
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  busy,
  output logic                  cs,
  output logic                  sclk,
  output logic                  mosi0,
  input  logic                  miso0
);

  localparam int EDGES   = 2 * DATA_WIDTH;
  localparam int SH_MAX  = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
  localparam int CNT_MAX = (EDGES > SH_MAX) ? EDGES : SH_MAX;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

  state_t                state_q, state_d;
  logic [DIV_W-1:0]      div_q, div_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  cpol_q, cpol_d, cpha_q, cpha_d, lsb_q, lsb_d;
  logic [DATA_WIDTH-1:0] tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d;
  logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
  logic                  rx_valid_q, rx_valid_d, busy_q, busy_d;
  logic                  cs_q, cs_d, sclk_q, sclk_d, mosi_q, mosi_d;
  logic                  tx_ready_q, tx_ready_d;

  logic                  lsb_in, tick;
  logic                  edge_go, edge_lead, edge_first;
  logic                  sample_now, advance_now;
  logic [DATA_WIDTH-1:0] tx_next;

`ifdef MASTER_SPI_LSB_FIRST_EN
  assign lsb_in = lsb_first;
`else
  assign lsb_in = 1'b0;
`endif

  // One tick per sclk half-period; the divider only runs outside IDLE.
  assign tick    = (div_q == DIV_W'(CLK_DIV - 1));
  assign tx_next = lsb_q ? {1'b0, tx_sh_q[DATA_WIDTH-1:1]}
                         : {tx_sh_q[DATA_WIDTH-2:0], 1'b0};

  // Next-state logic: phase sequencing, sclk edges, and data shifting.
  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    cnt_d      = cnt_q;
    cpol_d     = cpol_q;
    cpha_d     = cpha_q;
    lsb_d      = lsb_q;
    tx_sh_d    = tx_sh_q;
    rx_sh_d    = rx_sh_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    busy_d     = busy_q;
    cs_d       = cs_q;
    sclk_d     = sclk_q;
    mosi_d     = mosi_q;
    tx_ready_d = tx_ready_q;
    edge_go    = 1'b0;
    edge_lead  = 1'b0;
    edge_first = 1'b0;

    if (state_q != IDLE) div_d = tick ? '0 : div_q + DIV_W'(1);

    case (state_q)
      IDLE: begin
        if (tx_valid && tx_ready_q) begin
          state_d    = SETUP;
          div_d      = '0;
          cnt_d      = '0;
          cpol_d     = cpol;
          cpha_d     = cpha;
          lsb_d      = lsb_in;
          tx_sh_d    = tx_data;
          rx_sh_d    = '0;
          // The first bit is presented as cs falls, whatever the phase.
          mosi_d     = lsb_in ? tx_data[0] : tx_data[DATA_WIDTH-1];
          sclk_d     = cpol;
          cs_d       = 1'b0;
          busy_d     = 1'b1;
          tx_ready_d = 1'b0;
        end
      end
      SETUP: begin
        if (tick) begin
          if (cnt_q == CNT_W'(CS_SETUP - 1)) begin
            // The first sclk edge is what ends setup.
            state_d    = SHIFT;
            cnt_d      = CNT_W'(1);
            edge_go    = 1'b1;
            edge_lead  = 1'b1;
            edge_first = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      SHIFT: begin
        // cnt_q counts edges already produced. After the last edge, one
        // more idle half-period passes before hold.
        if (tick) begin
          if (cnt_q == CNT_W'(EDGES)) begin
            state_d = HOLD;
            cnt_d   = '0;
          end else begin
            cnt_d     = cnt_q + CNT_W'(1);
            edge_go   = 1'b1;
            edge_lead = ~cnt_q[0];
          end
        end
      end
      HOLD: begin
        if (tick) begin
          if (cnt_q == CNT_W'(CS_HOLD - 1)) begin
            state_d    = IDLE;
            cnt_d      = '0;
            cs_d       = 1'b1;
            busy_d     = 1'b0;
            tx_ready_d = 1'b1;
            rx_valid_d = 1'b1;
            rx_data_d  = rx_sh_q;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // cpha=0 samples on leading edges and shifts on trailing edges.
    // cpha=1 does the reverse. Under cpha=1 the first leading edge would
    // re-drive bit 0, so that edge is skipped.
    sample_now  = edge_go && (edge_lead ^ cpha_q);
    advance_now = edge_go && (cpha_q ? (edge_lead && !edge_first) : !edge_lead);

    if (edge_go) sclk_d = ~sclk_q;
    if (sample_now)
      rx_sh_d = lsb_q ? {miso0, rx_sh_q[DATA_WIDTH-1:1]}
                      : {rx_sh_q[DATA_WIDTH-2:0], miso0};
    if (advance_now) begin
      tx_sh_d = tx_next;
      mosi_d  = lsb_q ? tx_next[0] : tx_next[DATA_WIDTH-1];
    end
  end

  // State and output registers; reset aborts any transfer immediately.
  always_ff @(posedge pclk or posedge areset) begin
    if (areset) begin
      state_q    <= IDLE;
      div_q      <= '0;
      cnt_q      <= '0;
      cpol_q     <= 1'b0;
      cpha_q     <= 1'b0;
      lsb_q      <= 1'b0;
      tx_sh_q    <= '0;
      rx_sh_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      cs_q       <= 1'b1;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      tx_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      cnt_q      <= cnt_d;
      cpol_q     <= cpol_d;
      cpha_q     <= cpha_d;
      lsb_q      <= lsb_d;
      tx_sh_q    <= tx_sh_d;
      rx_sh_q    <= rx_sh_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      busy_q     <= busy_d;
      cs_q       <= cs_d;
      sclk_q     <= sclk_d;
      mosi_q     <= mosi_d;
      tx_ready_q <= tx_ready_d;
    end
  end

  assign tx_ready = tx_ready_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign busy     = busy_q;
  assign cs       = cs_q;
  assign sclk     = sclk_q;
  assign mosi0    = mosi_q;

endmodule

// File: tb/tb_master_spi_core.sv
// tb_master_spi_core: directed and random SPI transfers against a bench-side
// slave and frame model. The model derives expected words, edge counts and
// cs timing from the protocol rules.
module tb_master_spi_core;
  localparam int DW       = 8;
  localparam int CLK_DIV  = 2;
  localparam int CS_SETUP = 1;
  localparam int CS_HOLD  = 1;
  localparam int PER      = 10;
`ifdef MASTER_SPI_LSB_FIRST_EN
  localparam bit LSB_EN = 1'b1;
`else
  localparam bit LSB_EN = 1'b0;
`endif

  logic          pclk = 1'b0;
  logic          areset;
  logic [DW-1:0] tx_data;
  logic          tx_valid, tx_ready, cpol, cpha, lsb_first;
  logic [DW-1:0] rx_data;
  logic          rx_valid, busy, cs, sclk, mosi0, miso0;

  int            n_cmp = 0, n_fail = 0;
  int            rv_seen = 0, exp_rv = 0;
  logic [DW-1:0] exp_rx = '0;
  time           rise_t = 0;

  master_spi_core #(.DATA_WIDTH(DW), .CLK_DIV(CLK_DIV), .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD)) dut (
    .pclk(pclk), .areset(areset), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .cpol(cpol), .cpha(cpha),
`ifdef MASTER_SPI_LSB_FIRST_EN
    .lsb_first(lsb_first),
`endif
    .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy), .cs(cs), .sclk(sclk),
    .mosi0(mosi0), .miso0(miso0)
  );

  always #(PER/2) pclk = ~pclk;

  // Count rx_valid cycles so that pulse width and spurious pulses both show.
  always @(negedge pclk) if (rx_valid === 1'b1) rv_seen++;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic bsel(input logic [DW-1:0] w, input int i, input bit lsb);
    return lsb ? w[i] : w[DW-1-i];
  endfunction

  // Run one framed transfer from a negedge. tx is the word sent by the
  // master. sw is the word the slave returns.
  task automatic xfer(input logic [DW-1:0] tx, input logic [DW-1:0] sw, input bit cp, input bit ph,
                      input bit lsb, input int abort_at, input bit keep, input bit inject, input bit chk_gap);
    int edges, low, samples, badmosi, badspace, first_low, last_low, n, si;
    logic [DW-1:0] mw;
    logic prev_sclk, prev_mosi;
    bit lead, was_adv, aborted, inj_live, inj_done, eff_lsb;
    eff_lsb = lsb & LSB_EN;
    chk("rx_data_hold", rx_data, exp_rx);
    tx_data = tx; tx_valid = 1'b1; cpol = cp; cpha = ph; lsb_first = lsb;
    n = 0;
    while (tx_ready !== 1'b1 && n < 100) begin @(negedge pclk); n++; end
    chk("accept_ready", tx_ready, 1);
    @(negedge pclk);
    chk("cs_fall", cs, 0);
    chk("busy_set", busy, 1);
    chk("tx_ready_clr", tx_ready, 0);
    chk("sclk_idle_start", sclk, cp);
    if (chk_gap) chk("cs_high_gap", ($time - rise_t) / PER, 1);
    if (!keep) tx_valid = 1'b0;
    // Mid-transfer changes to mode and bit order must not take effect.
    cpol = 1'($urandom); cpha = 1'($urandom); lsb_first = 1'($urandom);
    if (!ph) miso0 = bsel(sw, 0, eff_lsb);
    prev_sclk = cp; prev_mosi = mosi0;
    edges = 0; low = 1; samples = 0; badmosi = 0; badspace = 0; first_low = 0; last_low = 0;
    mw = '0; aborted = 0; inj_live = 0; inj_done = 0;
    n = 0;
    while (n < 2000) begin
      @(negedge pclk); n++;
      if (inj_live) begin tx_valid = 1'b0; tx_data = tx; inj_live = 0; end
      if (cs !== 1'b0) break;
      low++;
      was_adv = 0;
      if (sclk !== prev_sclk) begin
        edges++;
        if (edges == 1) first_low = low;
        else if (low - last_low != CLK_DIV) badspace++;
        last_low = low;
        lead = edges[0];
        was_adv = ph ? lead : !lead;
        if (lead ^ ph) begin
          if (samples < DW) mw[eff_lsb ? samples : DW-1-samples] = mosi0;
          samples++;
        end
        if (was_adv) begin
          si = ph ? (edges - 1) / 2 : edges / 2;
          if (si < DW) miso0 = bsel(sw, si, eff_lsb);
        end
      end
      if (mosi0 !== prev_mosi && !was_adv) badmosi++;
      prev_sclk = sclk; prev_mosi = mosi0;
      if (inject && edges == 3 && !inj_done) begin
        tx_valid = 1'b1; tx_data = 8'hEE; inj_live = 1; inj_done = 1;
      end
      if (abort_at > 0 && edges == abort_at) begin aborted = 1; break; end
    end
    if (aborted) begin
      #2 areset = 1'b1;
      #1;
      chk("rst_cs", cs, 1);
      chk("rst_sclk", sclk, 0);
      chk("rst_busy", busy, 0);
      chk("rst_tx_ready", tx_ready, 1);
      chk("rst_mosi", mosi0, 0);
      chk("rst_rx_valid", rx_valid, 0);
      chk("rst_rx_data", rx_data, 0);
      exp_rx = '0;
      @(negedge pclk);
      chk("rst_hold_cs", cs, 1);
      tx_valid = 1'b0;
      areset = 1'b0;
      return;
    end
    chk("cs_rise", cs, 1);
    rise_t = $time;
    chk("cs_low_cycles", low, (CS_SETUP + 2*DW + CS_HOLD) * CLK_DIV);
    chk("first_edge_pos", first_low, CS_SETUP * CLK_DIV + 1);
    chk("edge_spacing_bad", badspace, 0);
    chk("sclk_edges", edges, 2*DW);
    chk("mosi_word", mw, tx);
    chk("mosi_timing_bad", badmosi, 0);
    chk("sclk_idle_end", sclk, cp);
    chk("rx_valid_end", rx_valid, 1);
    chk("rx_data_end", rx_data, sw);
    chk("tx_ready_end", tx_ready, 1);
    chk("busy_end", busy, 0);
    exp_rx = sw;
    exp_rv++;
  endtask

  initial begin
    areset = 1'b1; tx_valid = 1'b0; tx_data = '0; cpol = 1'b0; cpha = 1'b0;
    lsb_first = 1'b0; miso0 = 1'b0;
    repeat (3) @(negedge pclk);
    chk("reset_cs", cs, 1);
    chk("reset_sclk", sclk, 0);
    chk("reset_mosi", mosi0, 0);
    chk("reset_rx_data", rx_data, 0);
    chk("reset_rx_valid", rx_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_tx_ready", tx_ready, 1);
    areset = 1'b0;
    @(negedge pclk);

    // Mode 0, MSB first.
    xfer(8'hA5, 8'h3C, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge pclk);
    // Mode 3: sclk idles high, mosi moves on falling (leading) edges.
    xfer(8'h81, 8'hFF, 1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge pclk);
    // Back-to-back with tx_valid held throughout.
    xfer(8'h11, 8'h96, 1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0);
    xfer(8'h22, 8'h69, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1);
    repeat (2) @(negedge pclk);
    // A request pulsed while busy is dropped.
    xfer(8'h37, 8'hC8, 1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b1, 1'b0);
    repeat (2) @(negedge pclk);
    chk("no_queued_accept", busy, 0);
    // Abort after five edges, then transfer immediately after release.
    xfer(8'hC3, 8'h0F, 1'b1, 1'b0, 1'b0, 5, 1'b0, 1'b0, 1'b0);
    xfer(8'h5A, 8'hB4, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge pclk);
    // Bit-order selection; without the feature this stays MSB first.
    xfer(8'h01, 8'h80, 1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge pclk);

    for (int r = 0; r < 8; r++) begin
      xfer(DW'($urandom), DW'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
           0, 1'b0, 1'b0, 1'b0);
      repeat ($urandom_range(0, 3)) @(negedge pclk);
    end

    repeat (4) @(negedge pclk);
    chk("rx_valid_pulses", rv_seen, exp_rv);
    chk("rx_data_final_hold", rx_data, exp_rx);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
